ysyx_23060332_reg_wb_arb: RTL
=============================

// Module: ysyx_23060332_reg_wb_arb
// PURPOSE
//  Write-back arbiter and scoreboard for the 2R1W register file (32 x 32b, x0 hard-wired zero).
//  Shares the single register file write port between EXU and LSU write-back requesters.
//  Tracks outstanding destination writes per register and flags RAW hazards for the IDU read ports.
//  Sits between IDU/EXU/LSU and the register file; drives its waddr/wdata/reg_wen.
// PARAMETERS
//  DATA_W  32  register data width
//  ADDR_W  5   register address width (2**ADDR_W registers)
//  CNT_W   2   per-register outstanding-write counter width (max 2**CNT_W-1 pending)
// PORTS
//  clk         in   1       clock, all state updates on posedge
//  rst         in   1       synchronous reset, active-low (0 = reset)
//  iss_valid   in   1       IDU dispatches an instruction this cycle
//  iss_wen     in   1       dispatched instruction writes rd
//  iss_rd      in   ADDR_W  dispatched destination register
//  iss_ready   out  1       dispatch may be accepted (combinational)
//  exu_valid   in   1       EXU write-back request
//  exu_rd      in   ADDR_W  EXU destination
//  exu_data    in   DATA_W  EXU result
//  exu_ready   out  1       EXU request granted this cycle (combinational)
//  lsu_valid   in   1       LSU write-back request
//  lsu_rd      in   ADDR_W  LSU destination
//  lsu_data    in   DATA_W  LSU load data
//  lsu_ready   out  1       LSU request granted this cycle (combinational)
//  rf_wen      out  1       register file write enable (registered)
//  rf_waddr    out  ADDR_W  register file write address (registered)
//  rf_wdata    out  DATA_W  register file write data (registered)
//  raddr1      in   ADDR_W  IDU read address 1
//  raddr2      in   ADDR_W  IDU read address 2
//  hazard1     out  1       raddr1 has an outstanding write (combinational)
//  hazard2     out  1       raddr2 has an outstanding write (combinational)
//  sb_err      out  1       sticky: write-back to a register with zero outstanding count
// BEHAVIOUR
//  Reset (rst==0 at posedge): all cnt[] = 0, rf_wen=0, rf_waddr=0, rf_wdata=0, sb_err=0, last_grant=LSU.
//  Allocation: iss_fire = iss_valid & iss_ready; counts only if iss_wen & iss_rd!=0; then cnt[iss_rd]++.
//  iss_ready = 0 iff iss_wen & iss_rd!=0 & cnt[iss_rd]==max and no same-cycle decrement of iss_rd; else 1.
//  Arbitration (round-robin): one valid -> grant it; both valid -> grant the one not in last_grant.
//   Grant == ready; handshake = valid & ready; last_grant updates only on handshake.
//   Requester holds rd/data stable while valid & !ready.
//  Write port: handshake in cycle N -> rf_wen=1, rf_waddr/rf_wdata = winner's values in cycle N+1.
//   Winner rd==0: handshake consumed, rf_wen stays 0, no counter change. No handshake -> rf_wen=0.
//  Release: at posedge where rf_wen=1, cnt[rf_waddr]-- (same edge the register file commits).
//   Release with cnt[rf_waddr]==0: counter stays 0, sb_err<=1 (sticky until reset).
//  Simultaneous allocate + release on same register: net unchanged.
//  hazardN = (raddrN!=0) & (cnt[raddrN]!=0). x0 never hazards, never counted.
//  Reset mid-operation: pending write-backs dropped; rf_wen=0 the cycle after reset; counters cleared.
// CONFIGURATION
//  YSYX_23060332_WB_BYPASS_EN defined: adds outputs byp_valid1/byp_valid2 (1b), byp_data1/byp_data2 (DATA_W).
//   If rf_wen & rf_waddr==raddrN & raddrN!=0 & cnt[raddrN]==1: hazardN=0, byp_validN=1, byp_dataN=rf_wdata.
//   Otherwise byp_validN=0, byp_dataN=0.
//  Not defined: bypass ports absent; hazardN per counter rule only (1 extra stall cycle on every RAW).
// TESTING
//  Reset: rst=0 two cycles -> rf_wen=0, hazard1/2=0, sb_err=0, iss_ready=1.
//  Single path: issue rd=5; next cycle EXU rd=5 data=0xDEADBEEF -> exu_ready=1; next cycle rf_wen=1,
//   rf_waddr=5, rf_wdata=0xDEADBEEF; raddr1=5 hazard1=1 until after that edge, then 0.
//  Contention: issue rd=3 and rd=4; EXU(rd=3) and LSU(rd=4) valid same cycle -> EXU granted first,
//   LSU granted next cycle; both writes appear on consecutive rf_wen pulses.
//  Saturation (CNT_W=2): issue rd=7 three times -> iss_ready=0 for rd=7, still 1 for rd=8;
//   release one rd=7 write -> iss_ready=1 on that same cycle.
//  x0/error: write-back rd=0 -> no rf_wen, no sb_err; write-back rd=9 with cnt 0 -> sb_err=1 sticky.
//  Bypass (macro on): pending rd=6 write 0x12345678 on rf_wen, raddr2=6 -> hazard2=0, byp_valid2=1,
//   byp_data2=0x12345678; macro off -> hazard2=1 that cycle.

Source files
------------

// File: rtl/ysyx_23060332_reg_wb_arb_if.sv
// rtl/ysyx_23060332_reg_wb_arb_if.sv - dispatch, write-back, register-file and hazard bundle for the write-back arbiter
// Bypass signals exist only when YSYX_23060332_WB_BYPASS_EN is defined.
interface ysyx_23060332_reg_wb_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              iss_valid;
  logic              iss_wen;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic              exu_valid;
  logic [ADDR_W-1:0] exu_rd;
  logic [DATA_W-1:0] exu_data;
  logic              exu_ready;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              hazard1;
  logic              hazard2;
  logic              sb_err;
`ifdef YSYX_23060332_WB_BYPASS_EN
  logic              byp_valid1;
  logic              byp_valid2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
`endif

  modport master (
    output iss_valid, iss_wen, iss_rd, exu_valid, exu_rd, exu_data,
           lsu_valid, lsu_rd, lsu_data, raddr1, raddr2,
    input  iss_ready, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
           hazard1, hazard2, sb_err
`ifdef YSYX_23060332_WB_BYPASS_EN
    , input byp_valid1, byp_valid2, byp_data1, byp_data2
`endif
  );

  modport slave (
    input  iss_valid, iss_wen, iss_rd, exu_valid, exu_rd, exu_data,
           lsu_valid, lsu_rd, lsu_data, raddr1, raddr2,
    output iss_ready, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
           hazard1, hazard2, sb_err
`ifdef YSYX_23060332_WB_BYPASS_EN
    , output byp_valid1, byp_valid2, byp_data1, byp_data2
`endif
  );
endinterface

// File: rtl/ysyx_23060332_reg_wb_arb.sv
// rtl/ysyx_23060332_reg_wb_arb.sv - round-robin EXU/LSU write-back arbiter with per-register pending-write scoreboard
// Optional write-port bypass to the IDU read ports: YSYX_23060332_WB_BYPASS_EN.
module ysyx_23060332_reg_wb_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input logic clk,
  input logic rst,
  ysyx_23060332_reg_wb_arb_if.slave bus
);
  localparam int              NREG    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic            GNT_LSU = 1'b1;

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              last_grant_q, last_grant_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              sb_err_q, sb_err_d;

  logic              exu_gnt, lsu_gnt, wb_hs;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              iss_counts, iss_rel, iss_ready, iss_alloc;
  logic              byp1, byp2;

  always_comb begin : arbiter
    exu_gnt      = bus.exu_valid & (~bus.lsu_valid | (last_grant_q == GNT_LSU));
    lsu_gnt      = bus.lsu_valid & ~exu_gnt;
    wb_hs        = exu_gnt | lsu_gnt;
    win_rd       = exu_gnt ? bus.exu_rd : bus.lsu_rd;
    win_data     = exu_gnt ? bus.exu_data : bus.lsu_data;
    last_grant_d = wb_hs ? lsu_gnt : last_grant_q;
    // x0 write-backs are consumed here and never reach the register file
    rf_wen_d     = wb_hs & (win_rd != '0);
    rf_waddr_d   = rf_wen_d ? win_rd : rf_waddr_q;
    rf_wdata_d   = rf_wen_d ? win_data : rf_wdata_q;
  end

  always_comb begin : dispatch
    iss_counts = bus.iss_wen & (bus.iss_rd != '0);
    iss_rel    = rf_wen_q & (rf_waddr_q == bus.iss_rd);
    iss_ready  = ~(iss_counts & (cnt_q[bus.iss_rd] == CNT_MAX) & ~iss_rel);
    iss_alloc  = bus.iss_valid & iss_ready & iss_counts;
  end

  always_comb begin : scoreboard
    sb_err_d = sb_err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rf_wen_q && (rf_waddr_q == ADDR_W'(i))) begin
        if (cnt_q[i] == '0) sb_err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      if (iss_alloc && (bus.iss_rd == ADDR_W'(i))) cnt_d[i] = cnt_d[i] + CNT_ONE;
    end
  end

  always_comb begin : hazards
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef YSYX_23060332_WB_BYPASS_EN
    // last pending write is on the port right now: forward instead of stalling
    byp1 = rf_wen_q & (rf_waddr_q == bus.raddr1) & (bus.raddr1 != '0) & (cnt_q[bus.raddr1] == CNT_ONE);
    byp2 = rf_wen_q & (rf_waddr_q == bus.raddr2) & (bus.raddr2 != '0) & (cnt_q[bus.raddr2] == CNT_ONE);
    bus.byp_valid1 = byp1;
    bus.byp_valid2 = byp2;
    bus.byp_data1  = byp1 ? rf_wdata_q : '0;
    bus.byp_data2  = byp2 ? rf_wdata_q : '0;
`endif
    bus.hazard1 = (bus.raddr1 != '0) & (cnt_q[bus.raddr1] != '0) & ~byp1;
    bus.hazard2 = (bus.raddr2 != '0) & (cnt_q[bus.raddr2] != '0) & ~byp2;
  end

  assign bus.iss_ready = iss_ready;
  assign bus.exu_ready = exu_gnt;
  assign bus.lsu_ready = lsu_gnt;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.sb_err    = sb_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      last_grant_q <= GNT_LSU;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      sb_err_q     <= sb_err_d;
    end
  end
endmodule
